apb4_master_bridge: RTL and testbench
=====================================

Name: apb4_master_bridge

Overview:
- Single-outstanding APB4 requester that turns a simple valid/ready host request into APB4 SETUP/ACCESS transfers.
- Sits directly upstream of the two-slave APB4 decoder: drives the decoder's PSELx slave index and consumes its muxed PRDATA/PREADY/PSLVERR.
- Returns a one-cycle response pulse to the host.
- Supports back-to-back transfers without an IDLE bubble.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8.
- SEL_BIT, 12, address bit index that drives PSELx (0 selects slave 0, 1 selects slave 1); must be < ADDR_WIDTH.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB4_TIMEOUT_EN; must be ≥ 1.

Ports:
- PCLK  in  1  APB clock; all logic is rising-edge.
- PRESETn  in  1  Asynchronous active-low reset.
- req_valid  in  1  Host request valid.
- req_ready  out  1  Host request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  Transfer address.
- req_wdata  in  DATA_WIDTH  Write data.
- req_strb  in  DATA_WIDTH/8  Write byte strobes.
- req_prot  in  3  PPROT value.
- rsp_valid  out  1  One-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  Read data; 0 for writes.
- rsp_err  out  1  PSLVERR (or timeout) of the completed transfer.
- PSEL  out  1  Transfer active (SETUP or ACCESS).
- PSELx  out  1  Slave index to the decoder, = req_addr[SEL_BIT] captured at acceptance.
- PENABLE  out  1  High in ACCESS only.
- PADDR  out  ADDR_WIDTH  Registered address.
- PWRITE  out  1  Registered direction.
- PWDATA  out  DATA_WIDTH  Registered write data.
- PSTRB  out  DATA_WIDTH/8  Registered strobes; forced 0 on reads.
- PPROT  out  3  Registered protection.
- PRDATA  in  DATA_WIDTH  From decoder.
- PREADY  in  1  From decoder.
- PSLVERR  in  1  From decoder.

Behaviour:
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle.
  - ACCESS: PSEL=1, PENABLE=1. Held while PREADY=0.
- Transitions:
  - IDLE→SETUP on accept.
  - SETUP→ACCESS unconditionally.
  - ACCESS→ACCESS while PREADY=0.
  - ACCESS with PREADY=1: →SETUP if req_valid, else →IDLE.
- req_ready is combinational: (state==IDLE) || (state==ACCESS && PREADY). Never high in SETUP.
- Acceptance registers PADDR, PWRITE, PWDATA, PSTRB (req_write ? req_strb : 0), PPROT and PSELx.
- These outputs are stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE.
- Completion edge = ACCESS && PREADY. The next cycle drives rsp_valid=1 for exactly one cycle with:
  - rsp_err = PSLVERR sampled at the completion edge.
  - rsp_rdata = PRDATA for reads, 0 for writes.
- rsp_rdata and rsp_err hold their values after the pulse.
- PRDATA and PSLVERR are ignored in every cycle except the completion edge.
- Latency:
  - Accept at edge N → SETUP in cycle N+1, ACCESS in N+2.
  - With PREADY=1 in N+2, rsp_valid is high in N+3.
  - Minimum 2 cycles per transfer. Back-to-back transfers sustain 1 transfer per 2 cycles.
- Back-to-back: a response pulse for transfer k coincides with SETUP of transfer k+1.
- Reset (asynchronous, any state including mid-ACCESS):
  - State → IDLE.
  - PSEL, PENABLE, PWRITE, PSELx, rsp_valid, rsp_err → 0.
  - PADDR, PWDATA, PSTRB, PPROT, rsp_rdata → 0.
  - A transfer in flight is dropped with no response.
- A request held with req_valid=1 while req_ready=0 is not consumed. The host must keep it stable until accepted.

Optional Feature:
- Macro: APB4_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, the FSM leaves ACCESS as if PREADY=1, using the same next-state rule.
  - Response fields for a timed-out transfer: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - req_ready is also high in that cycle.
- Not defined: no counter exists. ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, zero wait:
  - Stimulus: req addr=0x0000_1004, wdata=0xDEADBEEF, strb=0xF.
  - Required: PSELx=1; SETUP then ACCESS with PREADY=1; PSTRB=0xF.
  - Required: rsp_valid exactly 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states:
  - Stimulus: addr=0x0000_0010, PREADY low for 3 ACCESS cycles, then PRDATA=0x12345678.
  - Required: PSELx=0; PSTRB=0; PADDR stable for 5 cycles; rsp_rdata=0x12345678.
  - Required: PRDATA=0xFFFFFFFF driven during the wait cycles is ignored.
- Back-to-back:
  - Stimulus: req_valid held high with write 0x1000 followed by read 0x0000.
  - Required: PSEL stays 1 throughout; PENABLE pattern 0,1,0,1.
  - Required: second SETUP coincides with the first rsp_valid; 2 responses total.
- Error:
  - Stimulus: read with PSLVERR=1 and PREADY=1.
  - Required: rsp_err=1. The next transfer with PSLVERR=0 returns rsp_err=0.
- Reset mid-ACCESS:
  - Stimulus: PRESETn low while PENABLE=1 and PREADY=0.
  - Required: PSEL, PENABLE and all outputs go to 0 immediately.
  - Required: no rsp_valid after reset release; req_ready=1 in IDLE.
- Timeout (APB4_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: PREADY held 0.
  - Required: ACCESS lasts 5 cycles; rsp_valid with rsp_err=1, rsp_rdata=0.
  - Required: without the macro, PENABLE stays 1 for 100 cycles.

Source files
------------

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 requester: host valid/ready request in, SETUP/ACCESS out, one-cycle response pulse back.
// Optional ACCESS-phase timeout is compiled in with `define APB4_TIMEOUT_EN.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_BIT        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PSELx,
    output logic                      PENABLE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic                      PWRITE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [2:0]                PPROT,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_W-1:0]       pstrb_q;
    logic [2:0]              pprot_q;
    logic                    pwrite_q, psel_x_q;
    logic                    rsp_valid_q, rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    timeout;
    logic                    done;
    logic                    accept;

`ifdef APB4_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A real PREADY in the limit cycle wins over the timeout.
    assign timeout = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !PREADY && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    assign done      = (state_q == ACCESS) && (PREADY || timeout);
    assign req_ready = (state_q == IDLE) || done;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = req_valid ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_x_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= done;
            if (accept) begin
                paddr_q  <= req_addr;
                pwdata_q <= req_wdata;
                pstrb_q  <= req_write ? req_strb : '0;
                pprot_q  <= req_prot;
                pwrite_q <= req_write;
                psel_x_q <= req_addr[SEL_BIT];
            end
            // Slave response is only looked at on the completion edge.
            if (done) begin
                rsp_err_q   <= timeout ? 1'b1 : PSLVERR;
                rsp_rdata_q <= (timeout || pwrite_q) ? '0 : PRDATA;
            end
        end
    end

    assign PSEL      = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PSELx     = psel_x_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed self-checking bench for apb4_master_bridge (TIMEOUT_CYCLES=4 so the timeout path is short).
module tb_apb4_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_cnt;

    apb4_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_BIT(12), .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic next_cycle;
        @(negedge PCLK);
    endtask

    initial begin
        PRESETn = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
        repeat (2) next_cycle();
        #1;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        next_cycle(); PRESETn = 1'b1;

        // Write, zero wait
        next_cycle();
        req_valid = 1; req_write = 1; req_addr = 32'h0000_1004; req_wdata = 32'hDEAD_BEEF;
        req_strb = 4'hF; req_prot = 3'b010; PREADY = 1; #1;
        check("wr_ready_idle", req_ready, 1);
        next_cycle(); req_valid = 0; #1;
        check("wr_setup_psel", PSEL, 1);
        check("wr_setup_penable", PENABLE, 0);
        check("wr_setup_ready", req_ready, 0);
        check("wr_pselx", PSELx, 1);
        check("wr_paddr", PADDR, 32'h0000_1004);
        check("wr_pwdata", PWDATA, 32'hDEAD_BEEF);
        check("wr_pstrb", PSTRB, 4'hF);
        check("wr_pprot", PPROT, 3'b010);
        check("wr_pwrite", PWRITE, 1);
        next_cycle(); #1;
        check("wr_access_penable", PENABLE, 1);
        check("wr_access_rsp", rsp_valid, 0);
        next_cycle(); #1;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_idle_psel", PSEL, 0);
        next_cycle(); #1;
        check("wr_rsp_pulse_end", rsp_valid, 0);

        // Read, 3 wait states, junk PRDATA/PSLVERR while waiting
        next_cycle();
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0010; req_strb = 4'hF;
        PREADY = 0; PRDATA = 32'hFFFF_FFFF; PSLVERR = 1; #1;
        next_cycle(); req_valid = 0; #1;
        check("rd_pselx", PSELx, 0);
        check("rd_pstrb", PSTRB, 0);
        n_cnt = (PADDR == 32'h10 && PSEL) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            if (PENABLE && PADDR == 32'h10 && !rsp_valid) n_cnt++;
        end
        next_cycle(); PREADY = 1; PRDATA = 32'h1234_5678; PSLVERR = 0; #1;
        if (PENABLE && PADDR == 32'h10) n_cnt++;
        check("rd_paddr_stable", n_cnt, 5);
        next_cycle(); PREADY = 0; PRDATA = 32'hFFFF_FFFF; #1;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", rsp_err, 0);
        next_cycle(); #1;
        check("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

        // Back-to-back: write 0x1000 then read 0x0000 with req_valid held
        next_cycle();
        req_valid = 1; req_write = 1; req_addr = 32'h0000_1000; req_wdata = 32'hA5; PREADY = 1; #1;
        next_cycle(); req_write = 0; req_addr = 32'h0; #1;
        check("b2b_c1_penable", {PSEL, PENABLE}, 2'b10);
        n_cnt = 0;
        next_cycle(); #1;
        check("b2b_c2_penable", {PSEL, PENABLE}, 2'b11);
        check("b2b_c2_ready", req_ready, 1);
        next_cycle(); req_valid = 0; PRDATA = 32'h0000_CAFE; #1;
        check("b2b_c3_penable", {PSEL, PENABLE}, 2'b10);
        check("b2b_c3_rsp_with_setup", rsp_valid, 1);
        check("b2b_c3_paddr", PADDR, 32'h0);
        check("b2b_c3_pwrite", PWRITE, 0);
        if (rsp_valid) n_cnt++;
        next_cycle(); #1;
        check("b2b_c4_penable", {PSEL, PENABLE}, 2'b11);
        if (rsp_valid) n_cnt++;
        next_cycle(); #1;
        if (rsp_valid) n_cnt++;
        check("b2b_rd_rdata", rsp_rdata, 32'h0000_CAFE);
        next_cycle(); #1;
        if (rsp_valid) n_cnt++;
        check("b2b_resp_count", n_cnt, 2);

        // Error then clean read
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0020; PREADY = 1; PSLVERR = 1; PRDATA = 32'h55; #1;
        next_cycle(); req_valid = 0; #1;
        next_cycle(); #1;
        next_cycle(); PSLVERR = 0; #1;
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_err", rsp_err, 1);
        req_valid = 1; req_addr = 32'h0000_0024; PRDATA = 32'h66;
        next_cycle(); req_valid = 0; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("err_clear_valid", rsp_valid, 1);
        check("err_clear_err", rsp_err, 0);
        check("err_clear_rdata", rsp_rdata, 32'h66);

        // Reset mid-ACCESS
        next_cycle();
        req_valid = 1; req_write = 1; req_addr = 32'h0000_1ABC; req_wdata = 32'h7777; PREADY = 0; #1;
        next_cycle(); req_valid = 0; #1;
        next_cycle(); #1;
        check("rstm_in_access", PENABLE, 1);
        #2 PRESETn = 1'b0; #1;
        check("rstm_psel", PSEL, 0);
        check("rstm_penable", PENABLE, 0);
        check("rstm_outs", {PSELx, PWRITE, PADDR, PWDATA, PSTRB, PPROT}, 0);
        check("rstm_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        next_cycle(); next_cycle(); PRESETn = 1'b1; PREADY = 1;
        n_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            if (rsp_valid) n_cnt++;
        end
        check("rstm_no_rsp", n_cnt, 0);
        check("rstm_ready_idle", req_ready, 1);

        // ACCESS with PREADY held low
        next_cycle();
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0030; PREADY = 0; PRDATA = 32'hBAD0_BAD0; #1;
        next_cycle(); req_valid = 0; #1;
        n_cnt = 0;
`ifdef APB4_TIMEOUT_EN
        next_cycle(); #1;
        while (PENABLE && n_cnt < 20) begin
            n_cnt++;
            next_cycle(); #1;
        end
        check("to_access_cycles", n_cnt, 5);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
`else
        for (int i = 0; i < 100; i++) begin
            next_cycle(); #1;
            if (PENABLE && !rsp_valid) n_cnt++;
        end
        check("noto_penable_held", n_cnt, 100);
`endif
        PRESETn = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
